// File: rtl/bus_sync_pulse_pkg.sv
// Shared constants for qualifier-based clock-domain crossings.
// Holds the legal synchroniser depth range and the edge-mode encodings.
package bus_sync_pulse_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    localparam int EDGE_RISE   = 0;
    localparam int EDGE_TOGGLE = 1;

endpackage

// File: rtl/bus_sync_pulse_bit_sync_chain.sv
// Single-bit multi-flop synchroniser into the CLK domain.
// Latency: NUM_STAGES CLK edges. No backpressure: samples every edge.
module bit_sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_bit,
    output logic sync_bit
);

    logic [NUM_STAGES-1:0] sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= '0;
        end else begin
            sync <= {sync[NUM_STAGES-2:0], async_bit};
        end
    end

    assign sync_bit = sync[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_pulse.sv
// Destination-side bus CDC: synchronised qualifier edge captures a held source bus.
// Latency: NUM_STAGES+1 CLK edges from qualifier sample to pulse. No backpressure.
module bus_sync_pulse
    import bus_sync_pulse_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic [CNT_WIDTH-1:0] CAPTURE_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    if (NUM_STAGES < MIN_SYNC_STAGES || NUM_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("bus_sync_pulse: NUM_STAGES must be within 2..4");
    end

    if (TOGGLE_MODE != EDGE_RISE && TOGGLE_MODE != EDGE_TOGGLE) begin : g_bad_mode
        $error("bus_sync_pulse: TOGGLE_MODE must be 0 or 1");
    end

    logic sync_last;
    logic prev;
    logic det;

    bit_sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_qual_sync (
        .CLK       (CLK),
        .RST       (RST),
        .async_bit (BUS_ENABLE),
        .sync_bit  (sync_last)
    );

    always_comb begin
        det = 1'b0;
        if (TOGGLE_MODE == EDGE_TOGGLE) begin
            det = sync_last ^ prev;
        end else begin
            det = sync_last & ~prev;
        end
    end

    // The bus is only sampled on det; the sender guarantees it is stable by then.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev         <= 1'b0;
            ENABLE_PULSE <= 1'b0;
            SYNC_BUS     <= '0;
            CAPTURE_CNT  <= '0;
        end else begin
            prev         <= sync_last;
            ENABLE_PULSE <= det;
            if (det) begin
                SYNC_BUS    <= UNSYNC_BUS;
                CAPTURE_CNT <= CAPTURE_CNT + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bus_sync_pulse.sv
// Bench for bus_sync_pulse: three configurations checked each cycle against a
// sample-history reference model, plus directed checks of the key scenarios.
module tb_bus_sync_pulse;

    logic CLK = 1'b0;
    logic RST;
    logic       en [3];
    logic [7:0] ub [3];

    logic [7:0] sb0, sb1, sb2;
    logic       ep0, ep1, ep2;
    logic [7:0] cc0, cc1;
    logic [1:0] cc2;

    always #5 CLK = ~CLK;

    // dut0: level, 2 stages; dut1: toggle, 3 stages; dut2: level, 2 stages, 2-bit counter
    bus_sync_pulse #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(0), .CNT_WIDTH(8)) dut0 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[0]), .BUS_ENABLE(en[0]),
        .SYNC_BUS(sb0), .ENABLE_PULSE(ep0), .CAPTURE_CNT(cc0));
    bus_sync_pulse #(.NUM_STAGES(3), .BUS_WIDTH(8), .TOGGLE_MODE(1), .CNT_WIDTH(8)) dut1 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[1]), .BUS_ENABLE(en[1]),
        .SYNC_BUS(sb1), .ENABLE_PULSE(ep1), .CAPTURE_CNT(cc1));
    bus_sync_pulse #(.NUM_STAGES(2), .BUS_WIDTH(8), .TOGGLE_MODE(0), .CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .UNSYNC_BUS(ub[2]), .BUS_ENABLE(en[2]),
        .SYNC_BUS(sb2), .ENABLE_PULSE(ep2), .CAPTURE_CNT(cc2));

    int checks = 0;
    int errors = 0;

    // Reference model: hist[d][i] is BUS_ENABLE sampled i edges ago (0 before reset release).
    // The pulse after edge k is decided by the samples taken at edges k-N and k-N-1.
    int         nst  [3] = '{2, 3, 2};
    bit         tog  [3] = '{1'b0, 1'b1, 1'b0};
    int         cmod [3] = '{256, 256, 4};
    bit         hist [3][8];
    bit         exp_p    [3];
    logic [7:0] exp_bus  [3];
    int         exp_cnt  [3];
    logic [7:0] last_bus [3];

    function automatic logic [31:0] get_bus(int d);
        case (d)
            0:       return {24'b0, sb0};
            1:       return {24'b0, sb1};
            default: return {24'b0, sb2};
        endcase
    endfunction

    function automatic logic [31:0] get_pulse(int d);
        case (d)
            0:       return {31'b0, ep0};
            1:       return {31'b0, ep1};
            default: return {31'b0, ep2};
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(int d);
        case (d)
            0:       return {24'b0, cc0};
            1:       return {24'b0, cc1};
            default: return {30'b0, cc2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input int d);
        bit a, b, det;
        if (RST) begin
            for (int i = 0; i < 8; i++) hist[d][i] = 1'b0;
            exp_p[d] = 1'b0; exp_bus[d] = 8'h00; exp_cnt[d] = 0;
        end else begin
            for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = en[d];
            a = hist[d][nst[d]];
            b = hist[d][nst[d]+1];
            det = tog[d] ? (a ^ b) : (a & ~b);
            exp_p[d] = det;
            if (det) begin
                exp_bus[d] = ub[d];
                exp_cnt[d] = (exp_cnt[d] + 1) % cmod[d];
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model_pulse%0d", d), get_pulse(d), {31'b0, exp_p[d]});
            chk($sformatf("model_bus%0d", d), get_bus(d), {24'b0, exp_bus[d]});
            chk($sformatf("model_cnt%0d", d), get_cnt(d), exp_cnt[d]);
            if (!RST && get_bus(d) !== {24'b0, last_bus[d]})
                chk($sformatf("bus_change_needs_pulse%0d", d), get_pulse(d), 1);
            last_bus[d] = get_bus(d)[7:0];
        end
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 0, 1};
        RST = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b0; ub[d] = 8'h00; last_bus[d] = 8'h00;
        end
        repeat (3) step();
        chk("rst_bus0", get_bus(0), 0);
        chk("rst_pulse1", get_pulse(1), 0);
        chk("rst_cnt2", get_cnt(2), 0);

        // Level capture on dut0 and toggle rise on dut1, both before edge 1
        RST = 1'b0;
        en[0] = 1'b1; ub[0] = 8'hA5;
        en[1] = 1'b1; ub[1] = 8'h11;
        step(); step();
        chk("lvl_no_early_pulse", get_pulse(0), 0);
        step();
        chk("lvl_pulse_edge3", get_pulse(0), 1);
        chk("lvl_bus_a5", get_bus(0), 8'hA5);
        chk("lvl_cnt_1", get_cnt(0), 1);
        chk("tog_no_early_pulse", get_pulse(1), 0);
        step();
        chk("lvl_pulse_one_cycle", get_pulse(0), 0);
        chk("tog_rise_pulse_edge4", get_pulse(1), 1);
        chk("tog_bus_11", get_bus(1), 8'h11);
        ub[0] = 8'h3C;
        repeat (6) step();

        // Toggle fall on dut1, ten cycles after its rise
        en[1] = 1'b0; ub[1] = 8'h22;
        repeat (3) step();
        chk("tog_fall_no_early", get_pulse(1), 0);
        step();
        chk("tog_fall_pulse_edge4", get_pulse(1), 1);
        chk("tog_bus_22", get_bus(1), 8'h22);
        chk("tog_cnt_2", get_cnt(1), 2);
        repeat (10) step();
        chk("lvl_hold_bus_a5", get_bus(0), 8'hA5);
        chk("lvl_hold_cnt_1", get_cnt(0), 1);

        // Counter wrap with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            en[2] = 1'b1; ub[2] = 8'($urandom);
            repeat (3) step();
            chk("wrap_pulse", get_pulse(2), 1);
            chk("wrap_cnt", get_cnt(2), seq[i]);
            en[2] = 1'b0;
            repeat (4) step();
        end

        // Reset while a rise is in flight, released with the qualifier still high
        en[0] = 1'b0;
        repeat (4) step();
        en[0] = 1'b1; ub[0] = 8'h5A;
        step();
        RST = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_rst_bus", get_bus(d), 0);
            chk("async_rst_pulse", get_pulse(d), 0);
            chk("async_rst_cnt", get_cnt(d), 0);
        end
        repeat (2) step();
        RST = 1'b0;
        repeat (2) step();
        chk("post_rst_no_early", get_pulse(0), 0);
        step();
        chk("post_rst_pulse", get_pulse(0), 1);
        chk("post_rst_cnt", get_cnt(0), 1);
        chk("post_rst_bus", get_bus(0), 8'h5A);
        step();
        chk("post_rst_single", get_pulse(0), 0);

        // Bus noise while the qualifier is low must not reach SYNC_BUS
        en[0] = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 30; i++) begin
            ub[0] = 8'($urandom);
            step();
            chk("noise_bus_stable", get_bus(0), 8'h5A);
        end

        // Random qualifier activity on all three configurations
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 3) == 0) en[d] = ~en[d];
                ub[d] = 8'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_sync_pulse.md
Name: bus_sync_pulse

Overview:
- Parametrised multi-bit CDC receiver.
- A single-bit qualifier (rising level or toggle, selectable) passes through a configurable N-flop synchroniser. Edge detection then produces a one-cycle enable pulse in the destination domain.
- The source data bus, held stable by the sender, is captured on that pulse.
- Sits at the destination side of every multi-bit crossing (register-file writes, UART RX data, ALU results). It extends the plain per-bit double-flop synchroniser with qualifier-based bus capture, a configurable stage count and a capture counter.

Parameters:
- NUM_STAGES, 2, synchroniser depth for the qualifier; legal range 2..4.
- BUS_WIDTH, 8, width of the data bus.
- TOGGLE_MODE, 0. 0: pulse on rising edge of synchronised qualifier. 1: pulse on any edge (toggle handshake).
- CNT_WIDTH, 8, width of the capture counter.

Ports:
- CLK, input, 1, destination-domain clock.
- RST, input, 1, asynchronous active-high reset.
- UNSYNC_BUS, input, BUS_WIDTH, source-domain data; sender holds it stable while BUS_ENABLE is asserted/toggled.
- BUS_ENABLE, input, 1, source-domain qualifier (level or toggle per TOGGLE_MODE).
- SYNC_BUS, output, BUS_WIDTH, captured data, registered.
- ENABLE_PULSE, output, 1, one-CLK-cycle strobe coincident with a new SYNC_BUS value, registered.
- CAPTURE_CNT, output, CNT_WIDTH, number of captures since reset, modulo 2^CNT_WIDTH.

Behaviour:
- Reset: RST high forces all synchroniser stages, the edge-history flop, SYNC_BUS, ENABLE_PULSE and CAPTURE_CNT to 0 immediately, independent of CLK. The first edge evaluated after release is relative to a qualifier history of 0.
- Synchroniser: sync[0] <= BUS_ENABLE and sync[k] <= sync[k-1] every CLK edge. Only BUS_ENABLE is synchronised; UNSYNC_BUS is never sampled except at capture.
- History flop: prev <= sync[NUM_STAGES-1] every edge.
- Edge detect (combinational): det = sync_last & ~prev when TOGGLE_MODE=0; det = sync_last ^ prev when TOGGLE_MODE=1.
- On an edge with det=1:
  - ENABLE_PULSE <= 1.
  - SYNC_BUS <= UNSYNC_BUS.
  - CAPTURE_CNT <= CAPTURE_CNT + 1, wrapping from all-ones to 0.
- On an edge with det=0: ENABLE_PULSE <= 0; SYNC_BUS and CAPTURE_CNT hold.
- Latency: BUS_ENABLE change sampled at CLK edge 1 → ENABLE_PULSE and new SYNC_BUS visible after edge NUM_STAGES+1. Pulse lasts exactly one cycle.
- Level mode:
  - BUS_ENABLE held high for many cycles gives one pulse only.
  - A new pulse requires BUS_ENABLE low for at least 1 destination cycle as seen after synchronisation.
  - A falling edge gives no pulse and no capture.
- Toggle mode: each qualifier transition gives exactly one pulse, including the 1→0 transition.
- Back-to-back: qualifier events separated by ≥1 destination cycle after synchronisation give distinct pulses on consecutive-or-later cycles. The bus value captured is whatever UNSYNC_BUS holds at the capture edge.
- Reset mid-operation: stages in flight are discarded; no pulse is emitted for them. After release, a qualifier still high produces a pulse NUM_STAGES+1 edges later in level mode. In toggle mode the same condition gives a pulse after NUM_STAGES+1 edges if the qualifier is high, because the history is 0.
- Illegal NUM_STAGES (<2 or >4): elaboration-time error.

Decomposition:
- Shared CDC package holds:
  - the MIN_SYNC_STAGES=2 and MAX_SYNC_STAGES=4 constants;
  - the edge-mode encoding constants EDGE_RISE=0 and EDGE_TOGGLE=1.
- One natural sub-module: bit_sync_chain. It is a NUM_STAGES-deep single-bit flop chain with async active-high reset, and is reusable by other crossings. Edge detect, capture and counter stay in the top.

Test Plan:
- Reset, then level mode with NUM_STAGES=2: UNSYNC_BUS=0xA5, BUS_ENABLE 0→1 before edge 1 → ENABLE_PULSE high for exactly the cycle after edge 3; SYNC_BUS=0xA5; CAPTURE_CNT=1.
- BUS_ENABLE held high 20 cycles, UNSYNC_BUS changed to 0x3C after the first pulse → no second pulse; SYNC_BUS stays 0xA5.
- Toggle mode, NUM_STAGES=3: BUS_ENABLE 0→1 with 0x11, then 1→0 ten cycles later with 0x22 → two pulses, each 4 edges after its toggle; SYNC_BUS 0x11 then 0x22; CAPTURE_CNT=2.
- CNT_WIDTH=2, five level-mode captures (pulse, low ≥3 cycles, repeat) → CAPTURE_CNT sequence 1,2,3,0,1.
- RST asserted one cycle after a BUS_ENABLE rise (while in flight), released with BUS_ENABLE still high → all outputs 0 during reset, with no glitch pulse. Exactly one pulse NUM_STAGES+1 edges after release, with CAPTURE_CNT=1.
- Randomised UNSYNC_BUS changes while BUS_ENABLE is low → SYNC_BUS never changes without a coincident ENABLE_PULSE.
